// File: rtl/aibcr3_dll_pkg.sv
// Shared types and helpers for the DLL interpolator thermometer controller.
// Helpers work at a fixed maximum width; callers slice to their own width.
package aibcr3_dll_pkg;

    localparam int MAX_GRAY_W  = 5;
    localparam int MAX_THERM_W = (1 << MAX_GRAY_W) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } dll_state_t;

    function automatic int therm_width(input int gray_w);
        return (1 << gray_w) - 1;
    endfunction

    // Narrower codes are zero-extended, which leaves the low bits unchanged.
    function automatic logic [MAX_GRAY_W-1:0] gray2bin(input logic [MAX_GRAY_W-1:0] g);
        logic [MAX_GRAY_W-1:0] b;
        b[MAX_GRAY_W-1] = g[MAX_GRAY_W-1];
        for (int i = MAX_GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_THERM_W-1:0] bin2therm(input logic [MAX_GRAY_W-1:0] code);
        logic [MAX_THERM_W-1:0] t;
        for (int i = 0; i < MAX_THERM_W; i++) begin
            t[i] = (i < int'(code));
        end
        return t;
    endfunction

endpackage

// File: rtl/aibcr3_dll_therm_sreg.sv
// Thermometer register: shifts up/down by one bit, loads a repaired pattern,
// or acts as a scan chain si -> q[0] -> ... -> q[W-1] -> so.
module aibcr3_dll_therm_sreg #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up,
    input  logic         down,
    input  logic         load_norm,
    input  logic [W-1:0] norm_val,
    input  logic         scan,
    input  logic         si,
    output logic [W-1:0] q,
    output logic         so
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (scan) begin
            q <= {q[W-2:0], si};
        end else if (load_norm) begin
            q <= norm_val;
        end else if (up) begin
            q <= {q[W-2:0], 1'b1};
        end else if (down) begin
            q <= {1'b0, q[W-1:1]};
        end
    end

    assign so = q[W-1];

endmodule

// File: rtl/aibcr3_dll_intp_therm_ctrl.sv
// Gray-coded phase target slewed one thermometer step per window into the
// interpolator; scan-chained, with pattern repair on scan exit.
module aibcr3_dll_intp_therm_ctrl
    import aibcr3_dll_pkg::*;
#(
    parameter  int GRAY_W     = 3,
    parameter  int SETTLE_CYC = 2,
    localparam int THERM_W    = therm_width(GRAY_W)
) (
    input  logic               CLKIN,
    input  logic               PDb,
    input  logic               iSE,
    input  logic               iSI,
    output logic               SOOUT,
    input  logic [GRAY_W-1:0]  gray,
    input  logic               load,
    input  logic               freeze,
    output logic [THERM_W-1:0] therm_p,
    output logic [THERM_W-1:0] therm_n,
    output logic [GRAY_W-1:0]  code_bin,
    output logic               busy,
    output logic               at_target
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    dll_state_t             state;
    logic [GRAY_W-1:0]      tgt;
    logic [GRAY_W-1:0]      tgt_dec;
    logic [CNT_W-1:0]       settle_cnt;
    logic                   scan_d;
    logic [THERM_W-1:0]     therm_q;
    logic [THERM_W-1:0]     norm_val;
    logic [MAX_GRAY_W-1:0]  bin_full;
    logic [MAX_THERM_W-1:0] therm_full;
    logic                   unused_bits;
    logic                   scan_exit;
    logic                   step_en;
    logic                   step_up;
    logic                   step_dn;

    assign bin_full = gray2bin(MAX_GRAY_W'(gray));
    assign tgt_dec  = bin_full[GRAY_W-1:0];

    // Applied code is the position of the highest set bit, so a corrupted
    // (non-thermometer) scan pattern still yields a well-defined code.
    always_comb begin
        code_bin = '0;
        for (int i = 0; i < THERM_W; i++) begin
            if (therm_q[i]) begin
                code_bin = GRAY_W'(i + 1);
            end
        end
    end

    assign therm_full  = bin2therm(MAX_GRAY_W'(code_bin));
    assign norm_val    = therm_full[THERM_W-1:0];
    assign unused_bits = ^{bin_full, therm_full};

    assign at_target = (code_bin == tgt);
    assign busy      = (state != IDLE) || !at_target;
    assign scan_exit = !iSE && scan_d;
    assign step_en   = !iSE && !scan_exit && (state == STEP);
    assign step_up   = step_en && (tgt > code_bin);
    assign step_dn   = step_en && !(tgt > code_bin);

    always_ff @(posedge CLKIN or negedge PDb) begin
        if (!PDb) begin
            state      <= IDLE;
            tgt        <= '0;
            settle_cnt <= '0;
            scan_d     <= 1'b0;
        end else begin
            scan_d <= iSE;
            if (load && !iSE) begin
                tgt <= tgt_dec;
            end
            if (iSE) begin
                state      <= IDLE;
                settle_cnt <= '0;
            end else if (!scan_d) begin
                case (state)
                    IDLE: begin
                        if (!at_target && !freeze) begin
                            state <= STEP;
                        end
                    end
                    STEP: begin
                        if (SETTLE_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                        end
                    end
                    SETTLE: begin
                        // freeze is deliberately ignored here: a started window always finishes.
                        if (settle_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    aibcr3_dll_therm_sreg #(
        .W (THERM_W)
    ) u_sreg (
        .clk       (CLKIN),
        .rst_n     (PDb),
        .up        (step_up),
        .down      (step_dn),
        .load_norm (scan_exit),
        .norm_val  (norm_val),
        .scan      (iSE),
        .si        (iSI),
        .q         (therm_q),
        .so        (SOOUT)
    );

    assign therm_p = therm_q;
    assign therm_n = ~therm_q;

endmodule

// File: tb/tb_aibcr3_dll_intp_therm_ctrl.sv
// Bench for the DLL thermometer controller: reference model per clock edge
// for the GRAY_W=3 instance, directed checks for a GRAY_W=4 instance.
module tb_aibcr3_dll_intp_therm_ctrl;

    localparam int GW  = 3;
    localparam int TW  = 7;
    localparam int SC  = 2;
    localparam int GW4 = 4;
    localparam int TW4 = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          pdb, ise, isi, load, freeze;
    logic [GW-1:0] gray;
    logic          soout, busy, at_target;
    logic [TW-1:0] therm_p, therm_n;
    logic [GW-1:0] code_bin;

    logic           pdb4, ise4, isi4, load4, freeze4;
    logic [GW4-1:0] gray4;
    logic           soout4, busy4, at_target4;
    logic [TW4-1:0] therm_p4, therm_n4;
    logic [GW4-1:0] code_bin4;

    int checks   = 0;
    int failures = 0;

    aibcr3_dll_intp_therm_ctrl #(.GRAY_W(GW), .SETTLE_CYC(SC)) dut (
        .CLKIN(clk), .PDb(pdb), .iSE(ise), .iSI(isi), .SOOUT(soout),
        .gray(gray), .load(load), .freeze(freeze),
        .therm_p(therm_p), .therm_n(therm_n), .code_bin(code_bin),
        .busy(busy), .at_target(at_target)
    );

    aibcr3_dll_intp_therm_ctrl #(.GRAY_W(GW4), .SETTLE_CYC(0)) dut4 (
        .CLKIN(clk), .PDb(pdb4), .iSE(ise4), .iSI(isi4), .SOOUT(soout4),
        .gray(gray4), .load(load4), .freeze(freeze4),
        .therm_p(therm_p4), .therm_n(therm_n4), .code_bin(code_bin4),
        .busy(busy4), .at_target(at_target4)
    );

    // Reference model: applied thermometer pattern, target as an integer, and
    // the number of edges left in the current step window (0 = evaluating).
    logic [TW-1:0] m_therm;
    int            m_tgt;
    int            m_hold;
    bit            m_scan_d;

    function automatic int m_code(input logic [TW-1:0] v);
        int c = 0;
        for (int i = 0; i < TW; i++) if (v[i]) c = i + 1;
        return c;
    endfunction

    function automatic int gray_to_int(input int g, input int w);
        for (int n = 0; n < (1 << w); n++) if ((n ^ (n >> 1)) == g) return n;
        return -1;
    endfunction

    task automatic model_reset();
        m_therm  = '0;
        m_tgt    = 0;
        m_hold   = 0;
        m_scan_d = 1'b0;
    endtask

    task automatic model_edge();
        int code;
        bit scan_prev;
        if (!pdb) begin
            model_reset();
            return;
        end
        code      = m_code(m_therm);
        scan_prev = m_scan_d;
        m_scan_d  = ise;
        if (ise) begin
            m_therm = {m_therm[TW-2:0], isi};
            m_hold  = 0;
        end else if (scan_prev) begin
            m_therm = TW'((1 << code) - 1);
        end else if (m_hold == SC + 1) begin
            if (m_tgt > code) m_therm = TW'((1 << (code + 1)) - 1);
            else              m_therm = TW'((1 << ((code > 0) ? code - 1 : 0)) - 1);
            m_hold--;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (code != m_tgt && !freeze) begin
            m_hold = SC + 1;
        end
        if (load && !ise) m_tgt = gray_to_int(int'(gray), GW);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int            code;
        logic [TW-1:0] inv;
        code = m_code(m_therm);
        inv  = ~m_therm;
        chk("therm_p", 32'(therm_p), 32'(m_therm));
        chk("therm_n", 32'(therm_n), 32'(inv));
        chk("code_bin", 32'(code_bin), 32'(code));
        chk("at_target", 32'(at_target), 32'(code == m_tgt));
        chk("busy", 32'(busy), 32'((m_hold != 0) || (code != m_tgt)));
        chk("soout", 32'(soout), 32'(m_therm[TW-1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_idle(input int budget, output int n, output int changes);
        logic [TW-1:0] prev;
        n = 0;
        changes = 0;
        do begin
            prev = therm_p;
            cyc();
            n++;
            if (therm_p !== prev) changes++;
        end while (busy === 1'b1 && n < budget);
    endtask

    task automatic wait_therm(input logic [TW-1:0] val, input int budget, input string tag);
        int n = 0;
        while (therm_p !== val && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(therm_p), 32'(val));
    endtask

    initial begin
        int n, changes;
        logic [TW4-1:0] prev4;
        logic [6:0] scan_bits;

        pdb = 1'b0; ise = 1'b0; isi = 1'b0; load = 1'b0; freeze = 1'b0; gray = '0;
        pdb4 = 1'b0; ise4 = 1'b0; isi4 = 1'b0; load4 = 1'b0; freeze4 = 1'b0; gray4 = '0;
        model_reset();
        cyc();
        cyc();
        pdb = 1'b1;
        pdb4 = 1'b1;
        repeat (3) cyc();

        // Full upward ramp 0 -> 7.
        gray = 3'b100; load = 1'b1; cyc(); load = 1'b0;
        run_idle(60, n, changes);
        chk("ramp_up_cycles", 32'(n), 32'd28);
        chk("ramp_up_steps", 32'(changes), 32'd7);
        chk("ramp_up_final", 32'(therm_p), 32'h7F);

        // Back down, then reverse mid-ramp at 0F toward target 1.
        gray = 3'b000; load = 1'b1; cyc(); load = 1'b0;
        run_idle(60, n, changes);
        chk("ramp_dn_steps", 32'(changes), 32'd7);
        gray = 3'b100; load = 1'b1; cyc(); load = 1'b0;
        wait_therm(7'h0F, 40, "reach_0f");
        gray = 3'b001; load = 1'b1;
        run_idle(40, n, changes);
        load = 1'b0;
        chk("reverse_steps", 32'(changes), 32'd3);
        chk("reverse_final", 32'(therm_p), 32'h01);

        // freeze during a settle window holds the code until released.
        gray = 3'b100; load = 1'b1; cyc(); load = 1'b0;
        wait_therm(7'h03, 20, "reach_03");
        freeze = 1'b1;
        repeat (12) cyc();
        chk("frozen_code", 32'(therm_p), 32'h03);
        freeze = 1'b0;
        n = 0;
        while (therm_p === 7'h03 && n < 10) begin
            cyc();
            n++;
        end
        chk("unfreeze_latency", 32'(n), 32'd2);
        run_idle(60, n, changes);
        chk("post_freeze_final", 32'(therm_p), 32'h7F);

        // Scan in 1,0,1,0,0,0,0 then exit: pattern repairs to 7F.
        scan_bits = 7'b1010000;
        ise = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            isi = scan_bits[i];
            cyc();
        end
        chk("scan_pattern", 32'(therm_p), 32'h50);
        ise = 1'b0; isi = 1'b0;
        cyc();
        chk("scan_exit_norm", 32'(therm_p), 32'h7F);
        cyc();

        // Randomized traffic including scan bursts, freeze and mid-ramp loads.
        for (int k = 0; k < 600; k++) begin
            gray   = GW'($urandom_range(0, 7));
            load   = ($urandom_range(0, 9) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            isi    = 1'($urandom_range(0, 1));
            if (ise) ise = ($urandom_range(0, 3) != 0);
            else     ise = ($urandom_range(0, 59) == 0);
            cyc();
        end
        ise = 1'b0; load = 1'b0; freeze = 1'b0; isi = 1'b0;
        cyc();

        // Power-down mid-ramp clears everything without waiting for a clock.
        gray = 3'b000; load = 1'b1; cyc(); load = 1'b0;
        run_idle(80, n, changes);
        gray = 3'b100; load = 1'b1; cyc(); load = 1'b0;
        repeat (9) cyc();
        #2;
        pdb = 1'b0;
        model_reset();
        #1;
        check_all();
        cyc();
        pdb = 1'b1;
        repeat (2) cyc();

        // Wider instance: 0 -> 15 with back-to-back windows.
        gray4 = 4'b1000; load4 = 1'b1; cyc(); load4 = 1'b0;
        n = 0; changes = 0;
        do begin
            prev4 = therm_p4;
            cyc();
            n++;
            if (therm_p4 !== prev4) changes++;
        end while (busy4 === 1'b1 && n < 80);
        chk("w4_cycles", 32'(n), 32'd30);
        chk("w4_steps", 32'(changes), 32'd15);
        chk("w4_therm_p", 32'(therm_p4), 32'h7FFF);
        chk("w4_therm_n", 32'(therm_n4), 32'h0);
        chk("w4_code", 32'(code_bin4), 32'd15);
        chk("w4_soout", 32'(soout4), 32'd1);

        gray4 = 4'b0000; load4 = 1'b1; cyc(); load4 = 1'b0;
        repeat (5) cyc();
        #2;
        pdb4 = 1'b0;
        #1;
        chk("w4_rst_therm_p", 32'(therm_p4), 32'h0);
        chk("w4_rst_therm_n", 32'(therm_n4), 32'h7FFF);
        chk("w4_rst_code", 32'(code_bin4), 32'd0);
        chk("w4_rst_busy", 32'(busy4), 32'd0);
        chk("w4_rst_at_target", 32'(at_target4), 32'd1);
        chk("w4_rst_soout", 32'(soout4), 32'd0);
        cyc();
        pdb4 = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
